// File: rtl/spu_fwd_scoreboard.sv
// Forwarding network and hazard scoreboard for an N-issue SPU pipeline.
// Each pipe keeps a DEPTH-stage shadow of its in-flight results. Source operands
// get the youngest matching in-flight result, or register-file data if none matches.
// A pipe stalls when that youngest producer has not computed its value yet.
module spu_fwd_scoreboard #(
    parameter int NUM_PIPES = 2,
    parameter int NUM_SRC   = 3,
    parameter int DEPTH     = 7,
    parameter int ADDR_WD   = 7,
    parameter int DATA_WD   = 128
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [NUM_PIPES-1:0]                 iss_valid,
    input  logic [NUM_PIPES-1:0]                 iss_wr_en,
    input  logic [NUM_PIPES*ADDR_WD-1:0]         iss_rt_addr,
    input  logic [NUM_PIPES*4-1:0]               iss_lat,
    input  logic [NUM_PIPES*DATA_WD-1:0]         res_data,
    input  logic [NUM_PIPES*NUM_SRC*ADDR_WD-1:0] src_addr,
    input  logic [NUM_PIPES*NUM_SRC*DATA_WD-1:0] rf_data,
    output logic [NUM_PIPES*NUM_SRC*DATA_WD-1:0] fw_data,
    output logic [NUM_PIPES-1:0]                 stall,
    output logic [NUM_PIPES-1:0]                 wb_en,
    output logic [NUM_PIPES*ADDR_WD-1:0]         wb_addr,
    output logic [NUM_PIPES*DATA_WD-1:0]         wb_data,
    output logic [NUM_PIPES*32-1:0]              stall_cnt
);

    localparam int LAT_WD = 4;
    localparam logic [LAT_WD-1:0] LAT_MAX = LAT_WD'(DEPTH - 1);

    // Shadow pipeline, indexed [pipe][stage]; stage 1 is the youngest.
    logic [NUM_PIPES-1:0][DEPTH:1]              vld_q;
    logic [NUM_PIPES-1:0][DEPTH:1]              wr_q;
    logic [NUM_PIPES-1:0][DEPTH:1][ADDR_WD-1:0] addr_q;
    logic [NUM_PIPES-1:0][DEPTH:1][LAT_WD-1:0]  lat_q;
    logic [NUM_PIPES-1:0][DEPTH:1]              rdy_q;
    logic [NUM_PIPES-1:0][DEPTH:1][DATA_WD-1:0] data_q;

    logic [NUM_PIPES-1:0][LAT_WD-1:0] lat_in;
    logic [NUM_PIPES-1:0][31:0]       cnt_q;

    assign stall_cnt = cnt_q;

    // Clamp issued latencies so every result is produced before it reaches write-back.
    always_comb begin
        lat_in = '0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            lat_in[p] = iss_lat[p*LAT_WD +: LAT_WD];
            if (lat_in[p] == '0 || int'(lat_in[p]) >= DEPTH) begin
                lat_in[p] = LAT_MAX;
            end
        end
    end

    // Advance the shadow pipeline, capturing each result as its entry leaves the lat stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            wr_q   <= '0;
            addr_q <= '0;
            lat_q  <= '0;
            rdy_q  <= '0;
            data_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                vld_q[p][1]  <= iss_valid[p] & ~flush;
                wr_q[p][1]   <= iss_wr_en[p];
                addr_q[p][1] <= iss_rt_addr[p*ADDR_WD +: ADDR_WD];
                lat_q[p][1]  <= lat_in[p];
                rdy_q[p][1]  <= 1'b0;
                data_q[p][1] <= '0;
                for (int k = 1; k < DEPTH; k++) begin
                    vld_q[p][k+1]  <= vld_q[p][k] & ~flush;
                    wr_q[p][k+1]   <= wr_q[p][k];
                    addr_q[p][k+1] <= addr_q[p][k];
                    lat_q[p][k+1]  <= lat_q[p][k];
                    if (vld_q[p][k] && int'(lat_q[p][k]) == k) begin
                        rdy_q[p][k+1]  <= 1'b1;
                        data_q[p][k+1] <= res_data[p*DATA_WD +: DATA_WD];
                    end else begin
                        rdy_q[p][k+1]  <= rdy_q[p][k];
                        data_q[p][k+1] <= data_q[p][k];
                    end
                end
            end
        end
    end

    // Pick the youngest producer per operand (oldest scanned first so younger overwrites) and flag unready ones.
    always_comb begin : fwd_select
        logic [ADDR_WD-1:0] want;
        logic               hit;
        logic               ok;
        logic [DATA_WD-1:0] pick;
        fw_data = '0;
        stall   = '0;
        want    = '0;
        hit     = 1'b0;
        ok      = 1'b0;
        pick    = '0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                want = src_addr[(p*NUM_SRC+s)*ADDR_WD +: ADDR_WD];
                hit  = 1'b0;
                ok   = 1'b0;
                pick = rf_data[(p*NUM_SRC+s)*DATA_WD +: DATA_WD];
                for (int k = DEPTH; k >= 1; k--) begin
                    for (int q = 0; q < NUM_PIPES; q++) begin
                        if (vld_q[q][k] && wr_q[q][k] && addr_q[q][k] == want) begin
                            hit = 1'b1;
                            if (rdy_q[q][k]) begin
                                ok   = 1'b1;
                                pick = data_q[q][k];
                            end else if (int'(lat_q[q][k]) == k) begin
                                ok   = 1'b1;
                                pick = res_data[q*DATA_WD +: DATA_WD];
                            end else begin
                                ok   = 1'b0;
                                pick = data_q[q][k];
                            end
                        end
                    end
                end
                fw_data[(p*NUM_SRC+s)*DATA_WD +: DATA_WD] = pick;
                if (hit && !ok) begin
                    stall[p] = 1'b1;
                end
            end
        end
    end

    // Register write-back from the last stage; a flush suppresses it like any other entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en   <= '0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                wb_en[p]                       <= vld_q[p][DEPTH] & wr_q[p][DEPTH] & ~flush;
                wb_addr[p*ADDR_WD +: ADDR_WD]  <= addr_q[p][DEPTH];
                wb_data[p*DATA_WD +: DATA_WD]  <= data_q[p][DEPTH];
            end
        end
    end

    // Count stall cycles per pipe, sticking at all-ones; flush leaves the counts alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                if (stall[p] && cnt_q[p] != 32'hFFFF_FFFF) begin
                    cnt_q[p] <= cnt_q[p] + 32'd1;
                end
            end
        end
    end

endmodule
